// File: rtl/usb_timer_pkg.sv
// Shared types and timing constants for the USB timer bank.
// One FS bit time equals one clk12 cycle, so all constants are in bit times.
package usb_timer_pkg;

    typedef enum logic [1:0] {
        WAIT_SIGNAL = 2'b00,
        ONESHOT     = 2'b01,
        PERIODIC    = 2'b10,
        WATCHDOG    = 2'b11
    } usb_timer_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } usb_timer_state_t;

    // Bus turnaround wait and full-speed frame length.
    localparam int unsigned USB_RX_TIMEOUT_CYCLES = 18;
    localparam int unsigned USB_FRAME_CYCLES      = 12000;

endpackage

// File: rtl/usb_timeout_channel.sv
// One timer channel: arms on start, counts to a latched limit, then expires,
// reloads (periodic) or is cut short by bus activity, depending on its mode.
module usb_timeout_channel
    import usb_timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 14
) (
    input  logic                 clk12_i,
    input  logic                 rst_i,
    input  logic                 rx_got_signal_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  usb_timer_mode_t      mode_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output usb_timer_state_t     state_o,
    output logic                 tick_o
);

    usb_timer_state_t     state_q, state_d;
    usb_timer_mode_t      mode_q, mode_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] limit_q, limit_d;
    logic                 tick_q, tick_d;
    logic [CNT_WIDTH-1:0] count_inc;
    logic [CNT_WIDTH-1:0] eff_limit;

    always_ff @(posedge clk12_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= WAIT_SIGNAL;
            count_q <= '0;
            limit_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            limit_q <= limit_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        limit_d   = limit_q;
        tick_d    = 1'b0;
        count_inc = count_q + 1'b1;
        // A zero limit behaves as one so an armed channel always expires.
        eff_limit = (limit_q == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : limit_q;

        if (stop_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start_i) begin
            state_d = RUN;
            count_d = '0;
            mode_d  = mode_i;
            limit_d = limit_i;
        end else if (state_q == RUN) begin
            if (rx_got_signal_i && (mode_q == WAIT_SIGNAL)) begin
                state_d = IDLE;
                count_d = '0;
            end else if (rx_got_signal_i && (mode_q == WATCHDOG)) begin
                count_d = '0;
            end else if (count_inc >= eff_limit) begin
                tick_d  = 1'b1;
                count_d = '0;
                if (mode_q != PERIODIC) begin
                    state_d = EXPIRED;
                end
            end else begin
                count_d = count_inc;
            end
        end
    end

    assign state_o = state_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/usb_timeout_bank.sv
// Bank of independent USB timer channels sharing the SIE activity pulse.
// Busy and timeout flags decode directly from each channel's registered state.
module usb_timeout_bank
    import usb_timer_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned CNT_WIDTH = 14
) (
    input  logic                          clk12_i,
    input  logic                          rst_i,
    input  logic                          rxGotSignal_i,
    input  logic [CHANNELS-1:0]           chStart_i,
    input  logic [CHANNELS-1:0]           chStop_i,
    input  logic [2*CHANNELS-1:0]         chMode_i,
    input  logic [CNT_WIDTH*CHANNELS-1:0] chLimit_i,
    output logic [CHANNELS-1:0]           chBusy_o,
    output logic [CHANNELS-1:0]           chTimeout_o,
    output logic [CHANNELS-1:0]           chTick_o
);

    usb_timer_state_t ch_state [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        usb_timeout_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk12_i        (clk12_i),
            .rst_i          (rst_i),
            .rx_got_signal_i(rxGotSignal_i),
            .start_i        (chStart_i[i]),
            .stop_i         (chStop_i[i]),
            .mode_i         (usb_timer_mode_t'(chMode_i[2*i +: 2])),
            .limit_i        (chLimit_i[CNT_WIDTH*i +: CNT_WIDTH]),
            .state_o        (ch_state[i]),
            .tick_o         (chTick_o[i])
        );

        assign chBusy_o[i]    = (ch_state[i] == RUN);
        assign chTimeout_o[i] = (ch_state[i] == EXPIRED);
    end

endmodule
